// File: rtl/spi_slave.sv
// SPI target for all four CPOL/CPHA modes, 8-bit frames, MSB first.
// The sclk, ss_b and mosi pins are resynchronised into the clk domain and edge-detected.
// One transmit byte is shifted out on miso for each frame.
// The received byte is presented on data_out with a one-cycle done pulse.
//
// Handshake: load is taken only while ready is high (IDLE).
// A load in the same cycle as a falling ss_b detection is also bypassed straight into the shifter.
// done is a single-cycle strobe; data_out is valid with it and holds until the next done.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       sclk,
    input  logic       ss_b,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic       sclk_prev, ss_prev;
    logic       sclk_s, ss_s, mosi_s;
    logic       leading, trailing, sample_edge, shift_edge;
    logic       ss_fall, ss_rise;
    logic       start_frame, take_bit, shift_out, last_bit;
    logic       byte_done;
    logic [7:0] tx_buf, so_reg, si_reg;
    logic [2:0] bit_cnt;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Synchronizer chains plus previous-value flops.
    // The sclk chain resets to the idle level so no false edge appears after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{cpol}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= cpol;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_b};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign leading     = (sclk_prev == cpol) && (sclk_s != cpol);
    assign trailing    = (sclk_prev != cpol) && (sclk_s == cpol);
    assign sample_edge = cpha ? trailing : leading;
    assign shift_edge  = cpha ? leading : trailing;
    assign ss_fall     = ss_prev & ~ss_s;
    assign ss_rise     = ~ss_prev & ss_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath strobes; a rising ss_b has priority over a sample edge.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        take_bit    = 1'b0;
        shift_out   = 1'b0;
        last_bit    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next  = SHIFT;
                    start_frame = 1'b1;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_next = IDLE;
                end else if (sample_edge) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = HOLD;
                        last_bit   = 1'b1;
                    end
                end else if (shift_edge && (bit_cnt != 3'd0)) begin
                    shift_out = 1'b1;
                end
            end
            HOLD: begin
                if (ss_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign ready = (state == IDLE);

    // Transmit buffer, shift registers, bit counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf    <= 8'h00;
            so_reg    <= 8'h00;
            si_reg    <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            done      <= 1'b0;
            data_out  <= 8'h00;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
        end else begin
            byte_done <= last_bit;
            done      <= byte_done;
            if (byte_done) data_out <= si_reg;
            if (load && ready) tx_buf <= data_in;
            if (start_frame) begin
                so_reg  <= load ? data_in : tx_buf;
                bit_cnt <= 3'd0;
            end
            if (take_bit) begin
                si_reg  <= {si_reg[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_out) so_reg <= {so_reg[6:0], 1'b0};
            miso    <= ss_s ? 1'b0 : so_reg[7];
            miso_oe <= ~ss_s;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-level SPI master drives the pins.
// A transaction-level model predicts the received bytes, the transmit byte and pin-enable timing.
module tb_spi_slave;

    localparam int S = 2;

    logic       clk, rst, cpol, cpha, sclk, ss_b, mosi;
    logic       miso, miso_oe, load, ready, done;
    logic [7:0] data_in, data_out;

    int         vectors, miscompares, done_cnt;
    logic [7:0] exp_q[$];
    logic [7:0] exp_data_out, exp_tx, rx, sent;
    logic       ss_hist[0:S];
    logic       check_en, rst_seen;
    int         d0, np;

    spi_slave #(.SYNC_STAGES(S)) dut (
        .clk(clk), .rst(rst), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_b(ss_b),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .data_in(data_in), .load(load),
        .ready(ready), .data_out(data_out), .done(done)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    // Pin enable, ready and idle miso follow the ss_b pin S cycles late.
    // Each done must match the next byte the master completed.
    always @(posedge clk) begin
        for (int i = S; i > 0; i--) ss_hist[i] = ss_hist[i-1];
        ss_hist[0] = ss_b;
        rst_seen = rst;
        #1;
        if (!rst_seen && check_en) begin
            check1("miso_oe", miso_oe, ~ss_hist[S]);
            check1("ready", ready, ss_hist[S]);
            if (ss_hist[S]) check1("miso_idle", miso, 1'b0);
            if (done) begin
                done_cnt++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: got done=1, expected no pending byte (t=%0t)", $time);
                end else begin
                    exp_data_out = exp_q.pop_front();
                end
            end
            check8("data_out", data_out, exp_data_out);
        end
    end

    task automatic set_mode(input bit p, input bit h);
        @(negedge clk);
        cpol = p;
        cpha = h;
        sclk = p;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] b);
        @(negedge clk);
        data_in = b;
        load    = 1'b1;
        exp_tx  = b;
        @(negedge clk);
        load = 1'b0;
    endtask

    // One SPI frame from the master side.
    // Fewer than 8 pulses is an abort; more than 8 adds extra sclk pulses in HOLD.
    task automatic frame(input logic [7:0] tx, input int npulses, input int half,
                         input bit bypass, input logic [7:0] bypass_val, input bit midload,
                         output logic [7:0] rx_o, output logic [7:0] sent_o);
        logic [7:0] r;
        r = 8'h00;
        @(negedge clk);
        ss_b = 1'b0;
        if (!cpha) mosi = tx[7];
        if (bypass) begin
            repeat (S) @(negedge clk);
            data_in = bypass_val;
            load    = 1'b1;
            exp_tx  = bypass_val;
            @(negedge clk);
            load = 1'b0;
            repeat (half - S - 1) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        sent_o = exp_tx;
        if (npulses >= 8) exp_q.push_back(tx);
        for (int i = 0; i < npulses; i++) begin
            if (!cpha && i < 8) r = {r[6:0], miso};
            if (cpha && i < 8) mosi = tx[7-i];
            sclk = ~cpol;
            if (midload && i == 2) begin
                data_in = 8'h99;
                load    = 1'b1;
            end
            repeat (half) @(negedge clk);
            load = 1'b0;
            if (cpha && i < 8) r = {r[6:0], miso};
            sclk = cpol;
            if (!cpha && i < 7) mosi = tx[6-i];
            repeat (half) @(negedge clk);
        end
        ss_b = 1'b1;
        repeat (half + S + 4) @(negedge clk);
        rx_o = r;
        if (npulses >= 8) begin
            check8("master_rx", r, sent_o);
            check_int("done_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; done_cnt = 0;
        rst = 1'b1; cpol = 1'b1; cpha = 1'b0; sclk = 1'b1; ss_b = 1'b1; mosi = 1'b0;
        load = 1'b0; data_in = 8'h00; exp_tx = 8'h00; exp_data_out = 8'h00; check_en = 1'b0;
        for (int i = 0; i <= S; i++) ss_hist[i] = 1'b1;

        // Reset with cpol=1 for two cycles.
        repeat (2) @(negedge clk);
        check1("rst_ready", ready, 1'b1);
        check1("rst_done", done, 1'b0);
        check1("rst_miso_oe", miso_oe, 1'b0);
        check1("rst_miso", miso, 1'b0);
        check8("rst_data_out", data_out, 8'h00);
        rst = 1'b0;
        check_en = 1'b1;
        repeat (10) @(negedge clk);
        check_int("rst_no_frame", done_cnt, 0);

        // Mode 0: slave 0xA5, master 0x3C.
        set_mode(1'b0, 1'b0);
        do_load(8'hA5);
        frame(8'h3C, 8, 5, 1'b0, 8'h00, 1'b0, rx, sent);
        check8("mode0_master_rx", rx, 8'hA5);
        check8("mode0_data_out", data_out, 8'h3C);
        check_int("mode0_done_cnt", done_cnt, 1);

        // Modes 1..3: slave 0x81, master 0x7E.
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0]);
            do_load(8'h81);
            frame(8'h7E, 8, 5, 1'b0, 8'h00, 1'b0, rx, sent);
            check8("modeN_master_rx", rx, 8'h81);
            check8("modeN_data_out", data_out, 8'h7E);
        end

        // Abort after 5 sample edges, then a full 0xC3 frame.
        set_mode(1'b0, 1'b0);
        d0 = done_cnt;
        frame(8'h55, 5, 6, 1'b0, 8'h00, 1'b0, rx, sent);
        check_int("abort_no_done", done_cnt, d0);
        check8("abort_data_out", data_out, 8'h7E);
        check1("abort_ready", ready, 1'b1);
        frame(8'hC3, 8, 6, 1'b0, 8'h00, 1'b0, rx, sent);
        check8("after_abort_data_out", data_out, 8'hC3);

        // Load bypass in the cycle falling ss_b is detected.
        frame(8'h24, 8, 5, 1'b1, 8'h5A, 1'b0, rx, sent);
        check8("bypass_master_rx", rx, 8'h5A);

        // Back-to-back frames with extra pulses and an ignored mid-frame load.
        d0 = done_cnt;
        frame(8'h11, 11, 5, 1'b0, 8'h00, 1'b1, rx, sent);
        check8("b2b_first_data_out", data_out, 8'h11);
        frame(8'hEE, 8, 5, 1'b0, 8'h00, 1'b0, rx, sent);
        check8("b2b_second_data_out", data_out, 8'hEE);
        check8("b2b_ignored_load", rx, 8'h5A);
        check_int("b2b_done_cnt", done_cnt - d0, 2);

        // Randomized frames: modes, loads, aborts, extra pulses, sclk rates.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom_range(0, 255)));
            np = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 11));
            frame(8'($urandom_range(0, 255)), np, int'($urandom_range(5, 8)), 1'b0, 8'h00, 1'b0, rx, sent);
        end

        repeat (10) @(negedge clk);
        check_int("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (target) supporting all four modes (CPOL/CPHA), 8-bit frames, MSB first. It is the receiving end of the team's SPI master on the same bus. It samples the external `sclk`, `ss_b` and `mosi` pins in the system clock domain, shifts out one transmit byte on `miso`, and presents the received byte with a single-cycle `done` pulse. It sits behind the pad ring and in front of a register file or FIFO on the target side.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `ss_b` and `mosi`. Must be ≥ 2.
- `clk` input 1: system clock. Single clock domain.
- `rst` input 1: reset, synchronous, active-high.
- `cpol` input 1: clock idle level. Must be static while a frame is in progress.
- `cpha` input 1: 0 = sample on the leading edge; 1 = sample on the trailing edge. Must be static while a frame is in progress.
- `sclk` input 1: SPI clock from the master. Asynchronous.
- `ss_b` input 1: slave select, active-low. Asynchronous.
- `mosi` input 1: master-out data. Asynchronous.
- `miso` output 1: slave-out data (current MSB of the shift register). Registered.
- `miso_oe` output 1: pad enable for `miso`. High while the synchronized `ss_b` is low.
- `data_in` input 8: transmit byte.
- `load` input 1: write `data_in` into the transmit buffer. Accepted only when `ready`=1.
- `ready` output 1: high in the IDLE state.
- `data_out` output 8: last complete received byte.
- `done` output 1: one-cycle pulse when a full byte is received.

## Operation
- Synchronizers: `sclk_s`, `ss_s` and `mosi_s` are the outputs of `SYNC_STAGES` flops. A `prev` flop on `sclk_s` and on `ss_s` provides edge detection.
- Edges:
  - leading = `sclk_s` moves away from `cpol`; trailing = `sclk_s` moves back to `cpol`.
  - sample edge = leading if `cpha`=0, else trailing; shift edge = the other edge.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - `ready`=1; `sclk` edges are ignored.
  - `load` latches `data_in` into `tx_buf`. `tx_buf` persists across frames and resets to 0x00.
  - Falling `ss_s` → SHIFT. In the same cycle, `so_reg` ← (`load` ? `data_in` : `tx_buf`) and `bit_cnt`←0. If `load` is high in this cycle, `tx_buf` is also written (bypass).
- SHIFT:
  - Sample edge: `si_reg` ← {`si_reg[6:0]`, `mosi_s`}; `bit_cnt`+1.
  - Shift edge with `bit_cnt` in 1..7: `so_reg` ← {`so_reg[6:0]`, 0}. With `cpha`=1, the first leading edge (`bit_cnt`=0) therefore does not shift.
  - 8th sample edge → HOLD. On the next cycle `data_out` ← the full byte and `done`=1 for exactly one cycle.
  - Rising `ss_s` before 8 samples: abort → IDLE. No `done`; `data_out` is unchanged; the partial byte is discarded.
- HOLD: all `sclk` edges are ignored; rising `ss_s` → IDLE.
- Outputs:
  - `miso` = registered `so_reg[7]`. It is driven 0 when `ss_s` is high.
  - `miso_oe` = ~`ss_s` (registered).
- `load` while `ready`=0 is ignored; `tx_buf` is unchanged.
- If a sample edge and a rising `ss_s` occur in the same cycle, the rising `ss_s` wins (abort or leave HOLD).

## Timing
- Reset values (applied on the clock edge with `rst`=1):
  - FSM = IDLE, so `ready`=1 from the first cycle after reset.
  - `done`=0, `data_out`=0x00, `miso`=0, `miso_oe`=0.
  - `so_reg`, `si_reg`, `tx_buf`, `bit_cnt` = 0.
  - `sclk` synchronizer chain and `prev` ← current `cpol`; `ss_b` chain and `prev` ← 1. This prevents a false edge after reset.
- Pin-to-detection latency: `SYNC_STAGES`+1 clk cycles from a pin edge to the internal edge strobe.
- `miso` changes `SYNC_STAGES`+2 cycles after the `sclk` shift edge at the pin.
- Bus constraint: each `sclk` half-period must be ≥ `SYNC_STAGES`+3 clk cycles. With the team master on the same clock, this means divisor ≥ `SYNC_STAGES`+2. The `ss_b` setup to the first `sclk` edge must meet the same bound.
- `done` asserts `SYNC_STAGES`+2 cycles after the 8th sample edge at the pin. `data_out` is valid in the same cycle and holds until the next `done`.
- `ready` falls in the cycle after falling `ss_s` is detected and rises in the cycle after rising `ss_s` is detected.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `cpol`=1 → `ready`=1, `done`=0, `miso_oe`=0, `miso`=0, `data_out`=0x00; no spurious frame.
- Mode 0, `load` 0xA5, master (divisor 4) sends 0x3C → exactly one `done` pulse, `data_out`=0x3C, master receives 0xA5.
- Modes 1, 2, 3 with divisor 4: slave loads 0x81, master sends 0x7E → `data_out`=0x7E and the master reads 0x81 in each mode.
- Abort: `ss_b` rises after 5 sample edges → no `done`, `data_out` keeps its previous value, `ready`=1. The next full frame of 0xC3 gives `data_out`=0xC3.
- `load` 0x5A in the same cycle that falling `ss_s` is detected → 0x5A is shifted out in that frame.
- Back-to-back frames 0x11 then 0xEE with 3 extra `sclk` pulses after bit 8 of frame 1 → exactly two `done` pulses, `data_out` 0x11 then 0xEE; a `load` while `ready`=0 is ignored.
